// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: FSM states, default slice
// width and the slice-count helper.
package csa_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int CHUNK_DEF = 4;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// Narrow carry-propagate slice: a CHUNK-bit ripple of single-bit full adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] c;

    assign c[0] = cin;
    assign cout = c[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end
endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into binary, one CHUNK-bit slice per clock,
// with the inter-slice carry held in a register.
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_width
        $fatal(1, "csa_resolver: WIDTH must be a multiple of CHUNK");
    end

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic             cin;
    logic [WIDTH-1:0] sum_q, carry_q;
    logic [CHUNK-1:0] a_slc, b_slc, s_slc;
    logic             cout;
    logic             last;
    int unsigned      base;

    assign last  = (idx == LAST);
    assign base  = 32'(idx) * CHUNK;
    assign a_slc = sum_q[base +: CHUNK];
    assign b_slc = carry_q[base +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a    (a_slc),
        .b    (b_slc),
        .cin  (cin),
        .s    (s_slc),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ADD;
            end
            ADD: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // result is filled slice by slice; the final carry lands in the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            idx     <= '0;
            cin     <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q   <= sum_vec;
                        carry_q <= carry_vec;
                        idx     <= '0;
                        cin     <= 1'b0;
                    end
                end
                ADD: begin
                    result[base +: CHUNK] <= s_slc;
                    cin                   <= cout;
                    if (last) begin
                        result[WIDTH] <= cout;
                        idx           <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
